// File: rtl/gpio_pio_irq.sv
// gpio_pio_irq: Avalon-MM GPIO block with an atomic set/clear output register,
// a two-flop synchronised input port, per-bit edge capture (W1C) and a
// maskable level interrupt.
// Optional feature macro: GPIO_DEBOUNCE_EN adds a per-bit stability-window
// debouncer of DEB_CYCLES clocks between the synchroniser and edge detection.
module gpio_pio_irq #(
   parameter int unsigned      IN_W       = 18,
   parameter int unsigned      OUT_W      = 27,
   parameter logic [OUT_W-1:0] OUT_RESET  = '0,
   parameter int unsigned      EDGE_MODE  = 0,
   parameter int unsigned      DEB_CYCLES = 50000
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [2:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq,
   input  logic [IN_W-1:0]   in_export,
   output logic [OUT_W-1:0]  out_export
);

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_OUT  = 3'd1;
   localparam logic [2:0] ADDR_SET  = 3'd2;
   localparam logic [2:0] ADDR_CLR  = 3'd3;
   localparam logic [2:0] ADDR_MASK = 3'd4;
   localparam logic [2:0] ADDR_EDGE = 3'd5;
   localparam logic [2:0] ADDR_INFO = 3'd6;

   localparam logic [31:0] INFO_WORD = {16'(OUT_W), 8'(IN_W), 6'b0, 2'(EDGE_MODE)};

   logic [OUT_W-1:0] out_q;
   logic [IN_W-1:0]  s1_q;
   logic [IN_W-1:0]  s2_q;
   logic [IN_W-1:0]  din;
   logic [IN_W-1:0]  din_prev_q;
   logic [IN_W-1:0]  edge_ev_c;
   logic [IN_W-1:0]  edge_q;
   logic [IN_W-1:0]  mask_q;
   logic [31:0]      rd_data_c;

   logic             wr_out;
   logic             wr_set;
   logic             wr_clr;
   logic             wr_mask;
   logic             wr_edge;
   logic [OUT_W-1:0] wd_out;
   logic [IN_W-1:0]  wd_in;
   logic             unused_ok;

   assign wr_out  = avs_write && (avs_address == ADDR_OUT);
   assign wr_set  = avs_write && (avs_address == ADDR_SET);
   assign wr_clr  = avs_write && (avs_address == ADDR_CLR);
   assign wr_mask = avs_write && (avs_address == ADDR_MASK);
   assign wr_edge = avs_write && (avs_address == ADDR_EDGE);
   assign wd_out  = avs_writedata[OUT_W-1:0];
   assign wd_in   = avs_writedata[IN_W-1:0];

   // Output register: plain write, atomic set and atomic clear.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_q <= OUT_RESET;
      end else if (wr_out) begin
         out_q <= wd_out;
      end else if (wr_set) begin
         out_q <= out_q | wd_out;
      end else if (wr_clr) begin
         out_q <= out_q & ~wd_out;
      end
   end

   assign out_export = out_q;

   // Two-flop synchroniser for the asynchronous input pins.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= in_export;
         s2_q <= s1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q [IN_W];
   logic [IN_W-1:0]  din_q;

   // Per-bit debounce: d only follows s2 after DEB_CYCLES consecutive differing cycles.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < int'(IN_W); i++) begin
            cnt_q[i] <= '0;
         end
         din_q <= '0;
      end else begin
         for (int i = 0; i < int'(IN_W); i++) begin
            if (s2_q[i] == din_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               cnt_q[i] <= '0;
               din_q[i] <= s2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign din       = din_q;
   assign unused_ok = ^avs_writedata;
`else
   assign din       = s2_q;
   assign unused_ok = ^{avs_writedata, 32'(DEB_CYCLES)};
`endif

   // Previous debounced value for edge detection.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         din_prev_q <= '0;
      end else begin
         din_prev_q <= din;
      end
   end

   // Edge event selection by configured mode.
   always_comb begin
      edge_ev_c = '0;
      case (EDGE_MODE)
         0:       edge_ev_c = din & ~din_prev_q;
         1:       edge_ev_c = ~din & din_prev_q;
         default: edge_ev_c = din ^ din_prev_q;
      endcase
   end

   // Edge capture: W1C clears, but a same-cycle edge event wins.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         edge_q <= '0;
      end else begin
         edge_q <= (edge_q & ~(wr_edge ? wd_in : '0)) | edge_ev_c;
      end
   end

   // Interrupt mask register.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         mask_q <= '0;
      end else if (wr_mask) begin
         mask_q <= wd_in;
      end
   end

   // Level interrupt straight from the EDGE and MASK flops.
   assign irq = |(edge_q & mask_q);

   // Read mux over the pre-write register values.
   always_comb begin
      rd_data_c = '0;
      case (avs_address)
         ADDR_DATA: rd_data_c = 32'(din);
         ADDR_OUT:  rd_data_c = 32'(out_q);
         ADDR_MASK: rd_data_c = 32'(mask_q);
         ADDR_EDGE: rd_data_c = 32'(edge_q);
         ADDR_INFO: rd_data_c = INFO_WORD;
         default:   rd_data_c = '0;
      endcase
   end

   // Registered read data, one cycle after the read strobe.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= rd_data_c;
      end
   end

endmodule
